// File: rtl/oric_sdm_dac.sv
// Multi-channel sigma-delta audio DAC with strobe-loaded samples and per-channel
// first/second-order modulators. Define SDM_DITHER_EN to add LFSR dither to the second-order path.
module oric_sdm_dac #(
    parameter int CHANNELS  = 2,
    parameter int WIDTH     = 16,
    parameter bit SIGNED_IN = 1'b0
) (
    input  logic                      clk_i,
    input  logic                      res_n_i,
    input  logic                      sample_stb_i,
    input  logic [CHANNELS*WIDTH-1:0] dac_i,
    input  logic [CHANNELS-1:0]       order_i,
    output logic                      busy_o,
    output logic [CHANNELS-1:0]       dac_o
);
    localparam int IW = WIDTH + 3;
    localparam int EW = WIDTH + 5;
    localparam logic signed [EW-1:0] HALF    = EW'(2 ** (WIDTH - 1));
    localparam logic signed [EW-1:0] SAT_MAX = EW'(2 ** (IW - 1) - 1);
    localparam logic signed [EW-1:0] SAT_MIN = EW'(-(2 ** (IW - 1)));

    function automatic logic signed [IW-1:0] sat(input logic signed [EW-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[IW-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[IW-1:0];
        end
        return v[IW-1:0];
    endfunction

    // run_q masks a strobe that lands on the first edge after reset release
    logic run_q;
    logic busy_q;
    logic accept;

    assign accept = sample_stb_i & run_q;
    assign busy_o = busy_q;

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            run_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            run_q  <= 1'b1;
            busy_q <= accept;
        end
    end

    logic dith;
`ifdef SDM_DITHER_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    assign dith   = lfsr_q[0];

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign dith = 1'b0;
`endif

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [WIDTH-1:0]     x_q;
        logic                 m_q;
        logic [WIDTH-1:0]     acc_q;
        logic [WIDTH-1:0]     acc_d;
        logic signed [IW-1:0] i1_q;
        logic signed [IW-1:0] i1_d;
        logic signed [IW-1:0] i2_q;
        logic signed [IW-1:0] i2_d;
        logic                 dac_q;
        logic                 dac_d;

        logic [WIDTH-1:0]     x_in;
        logic                 mode_chg;
        logic [WIDTH:0]       acc_sum;
        logic signed [EW-1:0] xs;
        logic signed [EW-1:0] fb;
        logic signed [EW-1:0] i1_x;
        logic signed [EW-1:0] i2_x;
        logic signed [EW-1:0] i1_nx;
        logic signed [IW-1:0] i1_n;
        logic signed [IW-1:0] i2_n;

        // Two's complement input becomes offset-binary by flipping the MSB
        assign x_in = SIGNED_IN ? {~dac_i[k*WIDTH+WIDTH-1], dac_i[k*WIDTH +: WIDTH-1]}
                                : dac_i[k*WIDTH +: WIDTH];
        assign mode_chg = accept & (order_i[k] != m_q);
        assign dac_o[k] = dac_q;

        always_comb begin
            acc_d   = acc_q;
            i1_d    = i1_q;
            i2_d    = i2_q;
            dac_d   = dac_q;
            acc_sum = {1'b0, acc_q} + {1'b0, x_q};
            xs      = $signed({5'b0, x_q}) - HALF + $signed({{(EW-1){1'b0}}, dith});
            fb      = dac_q ? HALF : -HALF;
            i1_x    = {{(EW-IW){i1_q[IW-1]}}, i1_q};
            i2_x    = {{(EW-IW){i2_q[IW-1]}}, i2_q};
            i1_n    = sat(i1_x + xs - fb);
            i1_nx   = {{(EW-IW){i1_n[IW-1]}}, i1_n};
            i2_n    = sat(i2_x + i1_nx - fb);
            if (mode_chg) begin
                acc_d = '0;
                i1_d  = '0;
                i2_d  = '0;
                dac_d = 1'b0;
            end else if (m_q) begin
                i1_d  = i1_n;
                i2_d  = i2_n;
                dac_d = ~i2_n[IW-1];
            end else begin
                acc_d = acc_sum[WIDTH-1:0];
                dac_d = acc_sum[WIDTH];
            end
        end

        always_ff @(posedge clk_i or negedge res_n_i) begin
            if (!res_n_i) begin
                x_q   <= '0;
                m_q   <= 1'b0;
                acc_q <= '0;
                i1_q  <= '0;
                i2_q  <= '0;
                dac_q <= 1'b0;
            end else begin
                if (accept) begin
                    x_q <= x_in;
                    m_q <= order_i[k];
                end
                acc_q <= acc_d;
                i1_q  <= i1_d;
                i2_q  <= i2_d;
                dac_q <= dac_d;
            end
        end
    end

endmodule
